// File: rtl/comparator_pkg.sv
// Shared constants, result encoding and flag payload for the 2-bit magnitude comparator.
package comparator_pkg;

    localparam int unsigned CMP_WIDTH = 2;

    // Three-way comparison outcome of A relative to B.
    typedef enum logic [1:0] {
        CMP_LT = 2'd0,
        CMP_EQ = 2'd1,
        CMP_GT = 2'd2
    } cmp_result_e;

    // One-hot flag triple as presented on the block outputs.
    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_flags_t;

    // Decode a comparison result into its one-hot flag triple.
    function automatic cmp_flags_t cmp_decode(input cmp_result_e res);
        cmp_flags_t flags;
        flags = '0;
        case (res)
            CMP_GT:  flags.gt = 1'b1;
            CMP_EQ:  flags.eq = 1'b1;
            default: flags.lt = 1'b1;
        endcase
        return flags;
    endfunction

endpackage

// File: rtl/comparator_core.sv
// Purely combinational unsigned magnitude compare, scanned MSB-first.
module comparator_core
    import comparator_pkg::*;
#(
    parameter int unsigned WIDTH = CMP_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output cmp_result_e      result_c
);

    logic gt_c;
    logic eq_c;
    logic decided_c;

    // The first differing bit from the MSB down decides greater; no differing bit means equal.
    always_comb begin
        gt_c      = 1'b0;
        decided_c = 1'b0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (!decided_c && (a_i[i] != b_i[i])) begin
                gt_c      = a_i[i] & ~b_i[i];
                decided_c = 1'b1;
            end
        end
        eq_c = ~decided_c;
        if (gt_c) begin
            result_c = CMP_GT;
        end else if (eq_c) begin
            result_c = CMP_EQ;
        end else begin
            result_c = CMP_LT;
        end
    end

endmodule

// File: rtl/comparator_2bit.sv
// Registered 2-bit unsigned comparator: one-cycle latency, one compare per cycle, one-hot flags.
module comparator_2bit
    import comparator_pkg::*;
#(
    parameter int unsigned WIDTH = CMP_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             A_greater,
    output logic             A_equal,
    output logic             A_less
);

    cmp_result_e result_c;
    cmp_flags_t  flags_d;
    cmp_flags_t  flags_q;

    comparator_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i      (A),
        .b_i      (B),
        .result_c (result_c)
    );

    // Turn the core result into the flag triple that gets registered.
    always_comb begin
        flags_d = cmp_decode(result_c);
    end

    // Output register stage; reset forces the all-zero idle state immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign A_greater = flags_q.gt;
    assign A_equal   = flags_q.eq;
    assign A_less    = flags_q.lt;

endmodule

// File: tb/tb_comparator_2bit.sv
// Self-checking bench for comparator_2bit against an integer-compare reference model.
module tb_comparator_2bit;

    logic       clk;
    logic       rst_n;
    logic [1:0] A;
    logic [1:0] B;
    logic       A_greater;
    logic       A_equal;
    logic       A_less;

    int n_checks;
    int n_fail;

    comparator_2bit #(.WIDTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .A_greater (A_greater),
        .A_equal   (A_equal),
        .A_less    (A_less)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: expected flag triple {gt,eq,lt} from plain integer compare.
    function automatic logic [2:0] ref_flags(input int a, input int b);
        return {a > b, a == b, a < b};
    endfunction

    // Present operands well away from the rising edge.
    task automatic drive(input int a, input int b);
        @(negedge clk);
        A = 2'(a);
        B = 2'(b);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        A = 2'b11;
        B = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({A_greater, A_equal, A_less} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_hold: got %b expected 000", {A_greater, A_equal, A_less});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({A_greater, A_equal, A_less} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_release_first_edge: got %b expected 100", {A_greater, A_equal, A_less});
        end
    endtask

    task automatic test_equal();
        for (int v = 0; v < 4; v++) begin
            drive(v, v);
            @(posedge clk);
            #1;
            n_checks++;
            if ({A_greater, A_equal, A_less} !== 3'b010) begin
                n_fail++;
                $display("FAIL equal_%0d: got %b expected 010", v, {A_greater, A_equal, A_less});
            end
        end
    endtask

    task automatic test_greater();
        int pa[3] = '{1, 2, 3};
        int pb[3] = '{0, 1, 2};
        for (int k = 0; k < 3; k++) begin
            drive(pa[k], pb[k]);
            @(posedge clk);
            #1;
            n_checks++;
            if ({A_greater, A_equal, A_less} !== 3'b100) begin
                n_fail++;
                $display("FAIL greater_%0d_%0d: got %b expected 100", pa[k], pb[k], {A_greater, A_equal, A_less});
            end
        end
    endtask

    task automatic test_less_boundary();
        drive(0, 3);
        @(posedge clk);
        #1;
        n_checks++;
        if ({A_greater, A_equal, A_less} !== 3'b001) begin
            n_fail++;
            $display("FAIL less_00_11: got %b expected 001", {A_greater, A_equal, A_less});
        end
        drive(3, 0);
        // Before the edge the previous result must still be held.
        #1;
        n_checks++;
        if ({A_greater, A_equal, A_less} !== 3'b001) begin
            n_fail++;
            $display("FAIL latency_hold: got %b expected 001", {A_greater, A_equal, A_less});
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({A_greater, A_equal, A_less} !== 3'b100) begin
            n_fail++;
            $display("FAIL greater_11_00: got %b expected 100", {A_greater, A_equal, A_less});
        end
    endtask

    task automatic test_midrun_reset();
        drive(2, 2);
        @(posedge clk);
        #1;
        n_checks++;
        if ({A_greater, A_equal, A_less} !== 3'b010) begin
            n_fail++;
            $display("FAIL midrun_pre_equal: got %b expected 010", {A_greater, A_equal, A_less});
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({A_greater, A_equal, A_less} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrun_async_clear: got %b expected 000", {A_greater, A_equal, A_less});
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({A_greater, A_equal, A_less} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrun_held_in_reset: got %b expected 000", {A_greater, A_equal, A_less});
        end
        drive(1, 3);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({A_greater, A_equal, A_less} !== 3'b001) begin
            n_fail++;
            $display("FAIL midrun_release: got %b expected 001", {A_greater, A_equal, A_less});
        end
    endtask

    // Back-to-back stream checked one cycle late against the model via a queue of applied pairs.
    task automatic run_stream(input string name, input int n, input bit exhaustive);
        int         qa[$];
        int         qb[$];
        int         a;
        int         b;
        int         ea;
        int         eb;
        logic [2:0] got;
        logic [2:0] exp;
        for (int c = 0; c <= n; c++) begin
            @(negedge clk);
            if (qa.size() > 0) begin
                ea  = qa.pop_front();
                eb  = qb.pop_front();
                got = {A_greater, A_equal, A_less};
                exp = ref_flags(ea, eb);
                n_checks++;
                if (got !== exp || $countones(got) != 1) begin
                    n_fail++;
                    $display("FAIL %s_%0d_%0d: got %b expected %b", name, ea, eb, got, exp);
                end
            end
            if (c < n) begin
                a = exhaustive ? (c >> 2) : int'($urandom_range(0, 3));
                b = exhaustive ? (c & 3)  : int'($urandom_range(0, 3));
                A = 2'(a);
                B = 2'(b);
                qa.push_back(a);
                qb.push_back(b);
            end
        end
    endtask

    task automatic test_exhaustive();
        run_stream("exhaustive", 16, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_stream("random", 200, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        A        = '0;
        B        = '0;
        test_reset();
        test_equal();
        test_greater();
        test_less_boundary();
        test_midrun_reset();
        test_exhaustive();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
